data_stream_transmitter: RTL and testbench

- Buffered, multi-mode successor to the single-shot UART word dumper, used for debug/result streaming to the host.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake into a FIFO_DEPTH-entry word FIFO.
- Serialises each word through the existing UartTx byte serializer as raw bytes (LSB- or MSB-first) or as uppercase ASCII hex, followed by a space or a CR LF terminator.
- Unlike its predecessor, it can accept new words while a frame is still being transmitted.

---
 rtl/data_stream_transmitter_pkg.sv | 38 +++
 rtl/UartTx.sv | 69 ++++++
 rtl/data_stream_transmitter_word_fifo.sv | 78 +++++++
 rtl/data_stream_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_data_stream_transmitter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_stream_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// data_stream_transmitter_pkg
// Purpose : shared word modes, ASCII constants, FSM state encoding and the
//           nibble-to-ASCII helper used by the data_stream_transmitter.
// Contents: MODE_* (per-word frame format), ASCII_* byte constants,
//           state_t (IDLE/POP/EMIT/GAP), nibble_to_ascii().
// -----------------------------------------------------------------------------
package data_stream_transmitter_pkg;

  // Per-word frame format, captured alongside each word in the FIFO
  localparam logic [1:0] MODE_RAW_LSB  = 2'd0;
  localparam logic [1:0] MODE_RAW_MSB  = 2'd1;
  localparam logic [1:0] MODE_HEX_SP   = 2'd2;
  localparam logic [1:0] MODE_HEX_CRLF = 2'd3;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_EMIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_0 + {4'd0, n};
    end else begin
      return ASCII_A + {4'd0, n} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/UartTx.sv
// -----------------------------------------------------------------------------
// UartTx
// Purpose : 8N1 UART byte serializer. One start bit, eight data bits LSB
//           first, one stop bit, each CLKS_PER_BIT clocks long.
// Ports   : clk, i_rst (sync, active-high)
//           i_wen   : load i_data and start a byte (only honoured when ready)
//           i_data  : byte to send
//           o_txd   : serial line, idles high; start bit is driven low on the
//                     edge that accepts i_wen
//           o_ready : serializer idle, can accept a byte this cycle
// -----------------------------------------------------------------------------
module UartTx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_wen,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_ready
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic              r_busy;
  logic              r_txd;
  logic [8:0]        r_shift;
  logic [3:0]        r_bit_cnt;
  logic [BAUD_W-1:0] r_baud_cnt;

  // r_bit_cnt: 0 = start bit on the line, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
    end else if (!r_busy) begin
      r_txd <= 1'b1;
      if (i_wen) begin
        r_busy     <= 1'b1;
        r_txd      <= 1'b0;
        r_shift    <= {1'b1, i_data};
        r_bit_cnt  <= '0;
        r_baud_cnt <= '0;
      end
    end else begin
      if (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) begin
        r_baud_cnt <= '0;
        if (r_bit_cnt == 4'd9) begin
          r_busy <= 1'b0;
          r_txd  <= 1'b1;
        end else begin
          // The top bit refills with 1 so the stop bit falls out last
          r_txd     <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

  assign o_txd   = r_txd;
  assign o_ready = !r_busy;

endmodule

// File: rtl/data_stream_transmitter_word_fifo.sv
// -----------------------------------------------------------------------------
// data_stream_transmitter_word_fifo
// Purpose : synchronous word FIFO holding {mode, data} entries for the
//           transmitter. Head entry is visible combinationally on o_rdata so
//           the consumer can latch it in the same cycle it pops.
// Ports   : clk, i_rst (sync, active-high)
//           i_push / i_wdata : write an entry (ignored when full)
//           i_pop            : discard the head entry (ignored when empty)
//           o_rdata          : head entry
//           o_full, o_empty, o_level : registered occupancy status
// -----------------------------------------------------------------------------
module data_stream_transmitter_word_fifo #(
  parameter int WIDTH     = 130,
  parameter int DEPTH     = 4,
  parameter int LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [LVL_WIDTH-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LVL_WIDTH-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == LVL_WIDTH'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Storage carries no reset; only the pointers and level define validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/data_stream_transmitter.sv
// -----------------------------------------------------------------------------
// data_stream_transmitter
// Purpose : buffered debug/result streamer. Words enter a FIFO over a
//           valid/ready handshake and are serialised through UartTx as raw
//           bytes (LSB- or MSB-first) or uppercase ASCII hex followed by a
//           space or CR LF. New words may be accepted while a frame is sent.
// Ports   : clk, i_rst (sync, active-high)
//           i_valid / o_ready : word handshake; push when both high at an edge
//           i_data  : word to send
//           i_mode  : 0 raw LSB-first, 1 raw MSB-first, 2 hex+SP, 3 hex+CRLF
//           o_txd   : registered UART serial line
//           o_busy  : FIFO non-empty or a frame in progress
//           o_level : FIFO occupancy
// -----------------------------------------------------------------------------
module data_stream_transmitter
  import data_stream_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int LVL_WIDTH    = $clog2(FIFO_DEPTH) + 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_mode,
  output logic                  o_txd,
  output logic                  o_busy,
  output logic [LVL_WIDTH-1:0]  o_level
);

  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int NNIBBLES = DATA_WIDTH / 4;
  localparam int CW       = $clog2(DATA_WIDTH / 4 + 3);

  // FIFO interface
  logic [DATA_WIDTH+1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  // Frame engine state
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [1:0]            r_mode;
  logic [CW-1:0]         r_cnt;
  logic                  r_txd;

  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [CW-1:0]         w_frame_len;
  logic [7:0]            w_byte;
  logic [3:0]            w_nibble;
  logic                  w_wen;
  logic                  w_uart_txd;
  logic                  w_uart_ready;

  assign w_push = i_valid && !w_full;
  assign w_pop  = (r_state == ST_POP);

  data_stream_transmitter_word_fifo #(
    .WIDTH     (DATA_WIDTH + 2),
    .DEPTH     (FIFO_DEPTH),
    .LVL_WIDTH (LVL_WIDTH)
  ) u_word_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({i_mode, i_data}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Number of bytes in the frame being sent
  always_comb begin
    w_frame_len = CW'(NBYTES);
    case (r_mode)
      MODE_HEX_SP:   w_frame_len = CW'(NNIBBLES + 1);
      MODE_HEX_CRLF: w_frame_len = CW'(NNIBBLES + 2);
      default:       w_frame_len = CW'(NBYTES);
    endcase
  end

  // Byte presented to UartTx; in hex modes the terminator bytes follow once
  // the counter has walked past every nibble.
  assign w_nibble = r_shift[DATA_WIDTH-1 -: 4];

  always_comb begin
    w_byte = r_shift[7:0];
    case (r_mode)
      MODE_RAW_LSB: w_byte = r_shift[7:0];
      MODE_RAW_MSB: w_byte = r_shift[DATA_WIDTH-1 -: 8];
      default: begin
        if (r_cnt < CW'(NNIBBLES)) begin
          w_byte = nibble_to_ascii(w_nibble);
        end else if (r_cnt == CW'(NNIBBLES)) begin
          w_byte = (r_mode == MODE_HEX_SP) ? ASCII_SP : ASCII_CR;
        end else begin
          w_byte = ASCII_LF;
        end
      end
    endcase
  end

  // Shift register advance after each emitted byte; in hex modes extra
  // shifts during the terminator are harmless because the data is spent.
  always_comb begin
    w_shift_next = r_shift;
    case (r_mode)
      MODE_RAW_LSB: w_shift_next = r_shift >> 8;
      MODE_RAW_MSB: w_shift_next = r_shift << 8;
      default:      w_shift_next = r_shift << 4;
    endcase
  end

  assign w_wen = (r_state == ST_EMIT) && w_uart_ready;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_mode  <= MODE_RAW_LSB;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_POP;
          end
        end
        ST_POP: begin
          r_shift <= w_head[DATA_WIDTH-1:0];
          r_mode  <= w_head[DATA_WIDTH+1:DATA_WIDTH];
          r_cnt   <= '0;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_uart_ready) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One dead cycle lets UartTx drop o_ready before the next byte;
          // going straight to POP keeps consecutive frames gap-free.
          if (r_cnt == w_frame_len) begin
            r_state <= w_empty ? ST_IDLE : ST_POP;
          end else begin
            r_state <= ST_EMIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  UartTx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wen   (w_wen),
    .i_data  (w_byte),
    .o_txd   (w_uart_txd),
    .o_ready (w_uart_ready)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_txd <= 1'b1;
    end else begin
      r_txd <= w_uart_txd;
    end
  end

  assign o_txd   = r_txd;
  assign o_ready = !w_full;
  assign o_busy  = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_data_stream_transmitter.sv
module tb_data_stream_transmitter;

  localparam int DW   = 32;
  localparam int DEPTH = 4;
  localparam int LVLW = 3;
  localparam int CPB  = 4;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic [1:0]      i_mode;
  logic            o_ready;
  logic            o_txd;
  logic            o_busy;
  logic [LVLW-1:0] o_level;

  int checks   = 0;
  int failures = 0;

  longint     cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  int         start_cnt = 0;

  data_stream_transmitter #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .LVL_WIDTH    (LVLW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .o_txd   (o_txd),
    .o_busy  (o_busy),
    .o_level (o_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: byte sequence of one frame, straight from the format rules
  task automatic model_frame(input logic [DW-1:0] d, input logic [1:0] m);
    int n;
    if (m == 2'd0) begin
      for (int k = 0; k < DW/8; k++) exp_q.push_back(8'(d >> (8*k)));
    end else if (m == 2'd1) begin
      for (int k = DW/8-1; k >= 0; k--) exp_q.push_back(8'(d >> (8*k)));
    end else begin
      for (int k = DW/4-1; k >= 0; k--) begin
        n = int'((d >> (4*k)) & 32'hF);
        exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
      end
      if (m == 2'd2) exp_q.push_back(8'h20);
      else begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bench UART receiver: samples mid-bit, drops a byte if reset is seen
  task automatic rx_wait(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (i_rst) ab = 1'b1;
    end
  endtask

  initial begin : receiver
    logic [7:0] b;
    bit         ab;
    longint     t0;
    forever begin
      @(negedge clk);
      if (!i_rst && o_txd === 1'b0) begin
        start_cnt++;
        t0 = cyc;
        ab = 1'b0;
        b  = '0;
        rx_wait(CPB/2, ab);
        for (int k = 0; k < 8; k++) begin
          rx_wait(CPB, ab);
          b[k] = o_txd;
        end
        rx_wait(CPB, ab);
        if (!ab) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  // Offer one word and hold it until accepted (bounded); model it on acceptance
  task automatic push(input logic [DW-1:0] d, input logic [1:0] m, input int budget);
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    for (int c = 0; c < budget; c++) begin
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("push_accepted", 64'(ok), 64'd1);
    if (ok) model_frame(d, m);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) @(negedge clk);
  endtask

  // Compare everything received against the model, then confirm silence
  task automatic drain(input string tag, input int budget);
    wait_rx(exp_q.size(), budget);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      chk({tag, "_byte"}, 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
    end
    repeat (45) @(negedge clk);
    chk({tag, "_no_extra"}, 64'(rx_q.size()), 64'd0);
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int            acc;
    int            base;
    int            c;
    logic [DW-1:0] w;
    logic [DW-1:0] wds[8];
    longint        gap_a;
    longint        gap_b;
    logic [7:0]    b0;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 2'd0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_txd",   64'(o_txd),   64'd1);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_level", 64'(o_level), 64'd0);

    // Hex + space
    push(32'h0123ABCD, 2'd2, 10);
    drain("hex_sp", 2000);
    chk("hex_sp_busy_low", 64'(o_busy), 64'd0);

    // Raw LSB then raw MSB back to back; byte spacing must not grow across the frame boundary
    push(32'h44434241, 2'd0, 10);
    push(32'h44434241, 2'd1, 10);
    wait_rx(8, 3000);
    gap_a = (rx_t.size() >= 5) ? (rx_t[1] - rx_t[0]) : -1;
    gap_b = (rx_t.size() >= 5) ? (rx_t[4] - rx_t[3]) : -2;
    chk("raw_frame_gap", 64'(gap_b), 64'(gap_a));
    drain("raw", 3000);

    // Hex + CR LF
    push(32'h0000000F, 2'd3, 10);
    drain("hex_crlf", 3000);

    // Back-pressure: valid held for 8 cycles, words 1..8
    acc = 0;
    w   = 32'd1;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_data  = w;
      i_mode  = 2'd0;
      if (o_ready === 1'b1) begin
        model_frame(w, 2'd0);
        acc++;
        w = w + 1;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_level",    64'(o_level), 64'd4);
    chk("bp_ready",    64'(o_ready), 64'd0);
    repeat (100) @(negedge clk);
    chk("bp_level_hold", 64'(o_level), 64'd4);
    chk("bp_ready_hold", 64'(o_ready), 64'd0);
    drain("bp", 6000);

    // Simultaneous push and pop at level 3
    base = start_cnt;
    for (int k = 0; k < 4; k++) push($urandom, 2'd0, 10);
    chk("pp_level3", 64'(o_level), 64'd3);
    c = 0;
    while (start_cnt < base + 4 && c < 3000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("pp_sync", 64'(start_cnt), 64'(base + 4));
    // Last start bit of frame 1 just appeared: the pop lands on the next edge
    w = $urandom;
    i_valid = 1'b1;
    i_data  = w;
    i_mode  = 2'd0;
    @(negedge clk);
    i_valid = 1'b0;
    model_frame(w, 2'd0);
    chk("pp_level_same", 64'(o_level), 64'd3);
    repeat (3) @(negedge clk);
    chk("pp_level_after", 64'(o_level), 64'd3);
    push($urandom, 2'd0, 10);
    chk("pp_full_level", 64'(o_level), 64'd4);
    chk("pp_full_ready", 64'(o_ready), 64'd0);
    w = $urandom;
    i_valid = 1'b1;
    i_data  = w;
    i_mode  = 2'd0;
    repeat (20) @(negedge clk);
    chk("pp_held_level", 64'(o_level), 64'd4);
    chk("pp_held_ready", 64'(o_ready), 64'd0);
    push(w, 2'd0, 1000);
    chk("pp_refill_level", 64'(o_level), 64'd4);
    drain("pp", 10000);

    // Reset during the 2nd byte with 3 words queued
    base = start_cnt;
    for (int k = 0; k < 4; k++) push($urandom, 2'd0, 10);
    c = 0;
    while (start_cnt < base + 2 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("rst_sync", 64'(start_cnt), 64'(base + 2));
    repeat (10) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("midrst_txd",   64'(o_txd),   64'd1);
    chk("midrst_level", 64'(o_level), 64'd0);
    chk("midrst_busy",  64'(o_busy),  64'd0);
    b0 = exp_q[0];
    exp_q.delete();
    exp_q.push_back(b0);
    repeat (200) @(negedge clk);
    chk("midrst_no_more", 64'(rx_q.size()), 64'd1);
    drain("midrst", 100);
    push($urandom, 2'd3, 10);
    drain("post_rst", 3000);

    // Randomised mixed-mode stream
    for (int k = 0; k < 8; k++) wds[k] = $urandom;
    for (int k = 0; k < 8; k++) push(wds[k], 2'($urandom_range(0, 3)), 2000);
    drain("random", 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
